// File: rtl/poly_step_sequencer_if.sv
// MIDI message handshake between the step sequencer and the note sender.
// Payload is registered by the sequencer and held until accepted.
interface poly_step_sequencer_if;
  logic       msg_valid;
  logic       msg_ready;
  logic [7:0] msg_status;
  logic [6:0] msg_data1;
  logic [6:0] msg_data2;

  modport master (output msg_valid, msg_status, msg_data1, msg_data2, input msg_ready);
  modport slave  (input msg_valid, msg_status, msg_data1, msg_data2, output msg_ready);
endinterface

// File: rtl/poly_step_sequencer.sv
// Multi-track step sequencer: walks per-track note patterns and emits paired
// note-off / note-on MIDI messages, flushing hanging notes when stopped.
//
// state    | meaning
// IDLE     | waiting for a step tick while running
// ADVANCE  | pick the next step index, step the LFSR
// SEND_OFF | note-off for every sounding track, ascending
// SEND_ON  | note-on for every non-rest track at the new step, ascending
// FLUSH    | stop: note-off for every sounding track, then rewind
module poly_step_sequencer #(
  parameter int          NUM_STEPS    = 8,
  parameter int          NUM_TRACKS   = 2,
  parameter logic [3:0]  CHANNEL_BASE = 4'd0,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  localparam int         IDX_W        = $clog2(NUM_STEPS),
  localparam int         TRK_W        = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       step_tick,
  input  logic                       run,
  input  logic [1:0]                 mode,
  input  logic                       wr_en,
  input  logic [TRK_W-1:0]           wr_track,
  input  logic [IDX_W-1:0]           wr_step,
  input  logic [6:0]                 wr_note,
  input  logic [6:0]                 wr_vel,
  poly_step_sequencer_if.master      msg,
  output logic [IDX_W-1:0]           step_idx,
  output logic                       busy,
  output logic                       overrun
);

  typedef enum logic [2:0] {IDLE, ADVANCE, SEND_OFF, SEND_ON, FLUSH} state_t;

  localparam logic [TRK_W-1:0] LAST_TRK  = TRK_W'(NUM_TRACKS - 1);
  localparam logic [IDX_W-1:0] LAST_STEP = IDX_W'(NUM_STEPS - 1);

  state_t                  state;
  logic [6:0]              pat_note [NUM_TRACKS][NUM_STEPS];
  logic [6:0]              pat_vel  [NUM_TRACKS][NUM_STEPS];
  logic [NUM_TRACKS-1:0]   active;
  logic [6:0]              active_note [NUM_TRACKS];
  logic [TRK_W-1:0]        trk;
  logic                    dir_up;
  logic                    started;
  logic                    run_q;
  logic [1:0]              mode_q;
  logic [15:0]             lfsr;

  logic [15:0]             lfsr_nxt;
  logic [IDX_W-1:0]        rnd;
  logic [IDX_W-1:0]        nxt_idx;
  logic                    nxt_dir_up;
  logic                    pp_up;
  logic                    is_on;
  logic                    trk_last;
  logic [6:0]              cur_note;
  logic [6:0]              cur_vel;
  logic                    want;
  logic                    stop_req;
  logic                    accept;
  logic                    trk_step;

  assign busy     = (state != IDLE);
  assign lfsr_nxt = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
  // A fresh entry into ping-pong always starts heading up.
  assign pp_up    = (mode_q != 2'd2) || dir_up;

  always_comb begin
    nxt_idx    = step_idx;
    nxt_dir_up = dir_up;
    rnd        = lfsr[IDX_W-1:0];
    if (int'(rnd) >= NUM_STEPS) rnd = rnd - IDX_W'(NUM_STEPS);
    case (mode)
      2'd0: nxt_idx = (step_idx == LAST_STEP) ? '0 : step_idx + 1'b1;
      2'd1: nxt_idx = (step_idx == '0) ? LAST_STEP : step_idx - 1'b1;
      2'd2: begin
        if (pp_up) begin
          if (step_idx == LAST_STEP) begin
            nxt_idx    = step_idx - 1'b1;
            nxt_dir_up = 1'b0;
          end else begin
            nxt_idx    = step_idx + 1'b1;
            nxt_dir_up = 1'b1;
          end
        end else if (step_idx == '0) begin
          nxt_idx    = IDX_W'(1);
          nxt_dir_up = 1'b1;
        end else begin
          nxt_idx    = step_idx - 1'b1;
        end
      end
      default: nxt_idx = rnd;
    endcase
  end

  always_comb begin
    is_on    = (state == SEND_ON);
    trk_last = (trk == LAST_TRK);
    cur_note = pat_note[trk][step_idx];
    cur_vel  = pat_vel[trk][step_idx];
    want     = is_on ? (cur_vel != 7'd0) : active[trk];
    stop_req = !run && (state != FLUSH);
    accept   = msg.msg_valid && msg.msg_ready;
    // A track slot is finished once its message is accepted, or at once if it has nothing to send.
    trk_step = msg.msg_valid ? msg.msg_ready : (!stop_req && !want);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      active         <= '0;
      trk            <= '0;
      dir_up         <= 1'b1;
      started        <= 1'b0;
      run_q          <= 1'b0;
      mode_q         <= 2'd0;
      lfsr           <= LFSR_SEED;
      step_idx       <= '0;
      overrun        <= 1'b0;
      msg.msg_valid  <= 1'b0;
      msg.msg_status <= 8'h00;
      msg.msg_data1  <= 7'h00;
      msg.msg_data2  <= 7'h00;
      for (int t = 0; t < NUM_TRACKS; t++) begin
        active_note[t] <= 7'h00;
        for (int s = 0; s < NUM_STEPS; s++) begin
          pat_note[t][s] <= 7'h00;
          pat_vel[t][s]  <= 7'h00;
        end
      end
    end else begin
      run_q <= run;
      if (run && !run_q) overrun <= 1'b0;
      if (step_tick && (state != IDLE)) overrun <= 1'b1;

      if (wr_en && (int'(wr_track) < NUM_TRACKS) && (int'(wr_step) < NUM_STEPS)) begin
        pat_note[wr_track][wr_step] <= wr_note;
        pat_vel[wr_track][wr_step]  <= wr_vel;
      end

      case (state)
        IDLE: begin
          if (step_tick && run) begin
            state <= ADVANCE;
          end else if (!run) begin
            if (|active) begin
              state <= FLUSH;
              trk   <= '0;
            end else begin
              started  <= 1'b0;
              step_idx <= '0;
              dir_up   <= 1'b1;
            end
          end
        end

        ADVANCE: begin
          lfsr   <= lfsr_nxt;
          mode_q <= mode;
          trk    <= '0;
          if (!started) begin
            started  <= 1'b1;
            step_idx <= (mode == 2'd1) ? LAST_STEP : '0;
            dir_up   <= 1'b1;
          end else begin
            step_idx <= nxt_idx;
            dir_up   <= nxt_dir_up;
          end
          state <= run ? SEND_OFF : FLUSH;
        end

        SEND_OFF, SEND_ON, FLUSH: begin
          if (accept) begin
            msg.msg_valid <= 1'b0;
            if (is_on) begin
              active[trk]      <= 1'b1;
              active_note[trk] <= msg.msg_data1;
            end else begin
              active[trk] <= 1'b0;
            end
          end else if (!msg.msg_valid && stop_req) begin
            state <= FLUSH;
            trk   <= '0;
          end else if (!msg.msg_valid && want) begin
            msg.msg_valid  <= 1'b1;
            msg.msg_status <= {is_on ? 4'h9 : 4'h8, CHANNEL_BASE + 4'(trk)};
            msg.msg_data1  <= is_on ? cur_note : active_note[trk];
            msg.msg_data2  <= is_on ? cur_vel : 7'h00;
          end

          if (trk_step) begin
            if (trk_last) begin
              trk <= '0;
              case (state)
                SEND_OFF: state <= SEND_ON;
                FLUSH: begin
                  state    <= IDLE;
                  started  <= 1'b0;
                  step_idx <= '0;
                  dir_up   <= 1'b1;
                end
                default:  state <= IDLE;
              endcase
            end else begin
              trk <= trk + 1'b1;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_step_sequencer.sv
// Self-checking bench: a 4-step and a 5-step sequencer share stimulus; a
// queue-based note model predicts messages and step order.
module tb_poly_step_sequencer;
  typedef logic [21:0] msg_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       step_tick = 1'b0;
  logic       run = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       wr_en = 1'b0;
  logic       wr_track = 1'b0;
  logic [2:0] wr_step = 3'd0;
  logic [6:0] wr_note = 7'd0;
  logic [6:0] wr_vel = 7'd0;
  logic       rdy_lvl = 1'b1;
  logic       rand_rdy = 1'b0;
  logic       rnd_bit = 1'b1;
  logic [1:0] idx4;
  logic [2:0] idx5;
  logic       busy4, busy5, ovr4, ovr5;

  poly_step_sequencer_if m4 ();
  poly_step_sequencer_if m5 ();
  assign m4.msg_ready = rand_rdy ? rnd_bit : rdy_lvl;
  assign m5.msg_ready = rand_rdy ? rnd_bit : rdy_lvl;

  poly_step_sequencer #(.NUM_STEPS(4), .NUM_TRACKS(2)) dut4 (
    .clk(clk), .rst_n(rst_n), .step_tick(step_tick), .run(run), .mode(mode),
    .wr_en(wr_en), .wr_track(wr_track), .wr_step(wr_step[1:0]), .wr_note(wr_note),
    .wr_vel(wr_vel), .msg(m4), .step_idx(idx4), .busy(busy4), .overrun(ovr4));

  poly_step_sequencer #(.NUM_STEPS(5), .NUM_TRACKS(2)) dut5 (
    .clk(clk), .rst_n(rst_n), .step_tick(step_tick), .run(run), .mode(mode),
    .wr_en(wr_en), .wr_track(wr_track), .wr_step(wr_step), .wr_note(wr_note),
    .wr_vel(wr_vel), .msg(m5), .step_idx(idx5), .busy(busy5), .overrun(ovr5));

  always #5 clk = ~clk;

  always @(negedge clk) rnd_bit = ($urandom_range(0, 2) != 0);

  msg_t got_q[$];
  msg_t exp_q[$];
  always @(posedge clk)
    if (rst_n && m4.msg_valid && m4.msg_ready)
      got_q.push_back({m4.msg_status, m4.msg_data1, m4.msg_data2});

  int checks = 0;
  int failures = 0;
  int rd = 0;

  // Note model of the 4-step instance: what is sounding and where the play head is.
  int          m_note [2][4];
  int          m_vel  [2][4];
  bit          m_act  [2];
  int          m_anote[2];
  int          m_idx, m_p, m_prev_mode;
  bit          m_started, m_ovr;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
    int fb;
    fb = (x[0] + x[2] + x[3] + x[5]) % 2;
    return 16'((int'(x) >> 1) + (fb << 15));
  endfunction

  function automatic void model_reset();
    for (int t = 0; t < 2; t++) begin
      m_act[t] = 0; m_anote[t] = 0;
      for (int s = 0; s < 4; s++) begin m_note[t][s] = 0; m_vel[t][s] = 0; end
    end
    m_idx = 0; m_p = 0; m_prev_mode = 0; m_started = 0; m_ovr = 0; m_lfsr = 16'hACE1;
  endfunction

  function automatic void model_tick(input int md);
    int nxt;
    if (!m_started) begin
      nxt = (md == 1) ? 3 : 0;
      m_started = 1;
      m_p = nxt;
    end else begin
      case (md)
        0: nxt = (m_idx + 1) % 4;
        1: nxt = (m_idx + 3) % 4;
        2: begin
          if (m_prev_mode != 2) m_p = m_idx;
          m_p = (m_p + 1) % 6;
          nxt = (m_p < 4) ? m_p : 6 - m_p;
        end
        default: begin
          nxt = int'(m_lfsr) % 4;
          if (nxt >= 4) nxt -= 4;
        end
      endcase
    end
    m_lfsr = lfsr_adv(m_lfsr);
    m_prev_mode = md;
    m_idx = nxt;
    for (int t = 0; t < 2; t++)
      if (m_act[t]) begin
        exp_q.push_back(msg_t'(((128 + t) << 14) + (m_anote[t] << 7)));
        m_act[t] = 0;
      end
    for (int t = 0; t < 2; t++)
      if (m_vel[t][nxt] != 0) begin
        exp_q.push_back(msg_t'(((144 + t) << 14) + (m_note[t][nxt] << 7) + m_vel[t][nxt]));
        m_act[t] = 1;
        m_anote[t] = m_note[t][nxt];
      end
  endfunction

  function automatic void model_stop();
    for (int t = 0; t < 2; t++)
      if (m_act[t]) begin
        exp_q.push_back(msg_t'(((128 + t) << 14) + (m_anote[t] << 7)));
        m_act[t] = 0;
      end
    m_started = 0;
    m_idx = 0;
  endfunction

  task automatic tick();
    step_tick = 1'b1;
    @(negedge clk);
    step_tick = 1'b0;
  endtask

  task automatic wr(input int t, input int s, input int n, input int v);
    wr_en = 1'b1; wr_track = t[0]; wr_step = s[2:0]; wr_note = n[6:0]; wr_vel = v[6:0];
    @(negedge clk);
    wr_en = 1'b0;
    if (s < 4) begin m_note[t][s] = n; m_vel[t][s] = v; end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy4 || busy5) && n < 800) begin @(negedge clk); n++; end
    if (busy4 || busy5) begin
      failures++;
      $display("FAIL %s_timeout busy4=%b busy5=%b required idle", tag, busy4, busy5);
    end
  endtask

  task automatic restart();
    run = 1'b0;
    model_stop();
    @(negedge clk);
    wait_idle("restart");
    run = 1'b1;
    m_ovr = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({m4.msg_valid, busy4, ovr4} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b required=000", {m4.msg_valid, busy4, ovr4});
    end
    checks++;
    if ({m4.msg_status, m4.msg_data1, m4.msg_data2} !== 22'h0) begin
      failures++; $display("FAIL reset_msg got=%h required=0", {m4.msg_status, m4.msg_data1, m4.msg_data2});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({idx4, idx5, busy4, busy5, m4.msg_valid} !== 8'h00) begin
      failures++; $display("FAIL reset_release got=%h required=00", {idx4, idx5, busy4, busy5, m4.msg_valid});
    end
  endtask

  task automatic test_forward();
    int exp_idx[6] = '{0, 1, 2, 3, 0, 1};
    for (int s = 0; s < 4; s++) wr(0, s, 60 + s, 100);
    mode = 2'd0;
    run = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      tick();
      model_tick(0);
      wait_idle("fwd");
      checks++;
      if (int'(idx4) != exp_idx[k]) begin
        failures++; $display("FAIL fwd_idx tick=%0d got=%0d required=%0d", k, idx4, exp_idx[k]);
      end
      while (rd < got_q.size()) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL fwd_msg got=%h required=none", got_q[rd]);
        end else begin
          if (got_q[rd] !== exp_q[0]) begin
            failures++; $display("FAIL fwd_msg got=%h required=%h", got_q[rd], exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        rd++;
      end
      checks++;
      if (exp_q.size() != 0) begin
        failures++; $display("FAIL fwd_missing left=%0d required=0", exp_q.size()); exp_q.delete();
      end
    end
    checks++;
    if (got_q[0] !== {8'h90, 7'h3C, 7'h64}) begin
      failures++; $display("FAIL fwd_first got=%h required=%h", got_q[0], {8'h90, 7'h3C, 7'h64});
    end
  endtask

  task automatic test_two_track();
    int base;
    wr(1, 0, 48, 80);
    wr(1, 1, 0, 0);
    restart();
    for (int k = 0; k < 2; k++) begin
      base = got_q.size();
      tick();
      model_tick(0);
      wait_idle("two");
      while (rd < got_q.size()) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL two_msg got=%h required=none", got_q[rd]);
        end else begin
          if (got_q[rd] !== exp_q[0]) begin
            failures++; $display("FAIL two_msg got=%h required=%h", got_q[rd], exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        rd++;
      end
      checks++;
      if (exp_q.size() != 0) begin
        failures++; $display("FAIL two_missing left=%0d required=0", exp_q.size()); exp_q.delete();
      end
    end
    checks++;
    if (got_q.size() != base + 3 || got_q[base] !== {8'h80, 7'h3C, 7'h00} ||
        got_q[base+1] !== {8'h81, 7'h30, 7'h00} || got_q[base+2] !== {8'h90, 7'h3D, 7'h64}) begin
      failures++;
      $display("FAIL two_order got=%h,%h,%h required=%h,%h,%h", got_q[base], got_q[base+1], got_q[base+2],
               {8'h80, 7'h3C, 7'h00}, {8'h81, 7'h30, 7'h00}, {8'h90, 7'h3D, 7'h64});
    end
  endtask

  task automatic test_pingpong();
    int exp_idx[8] = '{0, 1, 2, 3, 2, 1, 0, 1};
    mode = 2'd2;
    restart();
    for (int k = 0; k < 8; k++) begin
      tick();
      model_tick(2);
      wait_idle("pp");
      checks++;
      if (int'(idx4) != exp_idx[k]) begin
        failures++; $display("FAIL pp_idx tick=%0d got=%0d required=%0d", k, idx4, exp_idx[k]);
      end
      while (rd < got_q.size()) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL pp_msg got=%h required=none", got_q[rd]);
        end else begin
          if (got_q[rd] !== exp_q[0]) begin
            failures++; $display("FAIL pp_msg got=%h required=%h", got_q[rd], exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        rd++;
      end
      checks++;
      if (exp_q.size() != 0) begin
        failures++; $display("FAIL pp_missing left=%0d required=0", exp_q.size()); exp_q.delete();
      end
    end
  endtask

  task automatic test_stall();
    msg_t held;
    mode = 2'd0;
    rdy_lvl = 1'b0;
    tick();
    model_tick(0);
    repeat (3) @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      held = {m4.msg_status, m4.msg_data1, m4.msg_data2};
      if (c % 5 == 0) begin
        checks++;
        if (m4.msg_valid !== 1'b1 || held !== exp_q[0]) begin
          failures++; $display("FAIL stall_hold cyc=%0d valid=%b got=%h required=%h", c, m4.msg_valid, held, exp_q[0]);
        end
      end
      if (c == 10) begin tick(); m_ovr = 1; end
      else @(negedge clk);
    end
    checks++;
    if (ovr4 !== m_ovr || int'(idx4) != m_idx) begin
      failures++; $display("FAIL stall_overrun got ovr=%b idx=%0d required ovr=%b idx=%0d", ovr4, idx4, m_ovr, m_idx);
    end
    rdy_lvl = 1'b1;
    wait_idle("stall");
    while (rd < got_q.size()) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL stall_msg got=%h required=none", got_q[rd]);
      end else begin
        if (got_q[rd] !== exp_q[0]) begin
          failures++; $display("FAIL stall_msg got=%h required=%h", got_q[rd], exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      rd++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL stall_missing left=%0d required=0", exp_q.size()); exp_q.delete();
    end
  endtask

  task automatic test_stop();
    for (int k = 0; k < 2; k++) begin
      tick();
      model_tick(0);
      wait_idle("stop_pre");
    end
    checks++;
    if (ovr4 !== m_ovr || !(m_act[0] && m_act[1])) begin
      failures++; $display("FAIL stop_pre got ovr=%b required ovr=%b with both tracks sounding", ovr4, m_ovr);
    end
    run = 1'b0;
    model_stop();
    @(negedge clk);
    wait_idle("stop");
    while (rd < got_q.size()) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++; $display("FAIL stop_msg got=%h required=none", got_q[rd]);
      end else begin
        if (got_q[rd] !== exp_q[0]) begin
          failures++; $display("FAIL stop_msg got=%h required=%h", got_q[rd], exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
      rd++;
    end
    checks++;
    if (exp_q.size() != 0 || busy4 !== 1'b0) begin
      failures++; $display("FAIL stop_flush left=%0d busy=%b required 0 and 0", exp_q.size(), busy4);
      exp_q.delete();
    end
    run = 1'b1;
    m_ovr = 0;
    @(negedge clk);
    checks++;
    if (ovr4 !== 1'b0) begin
      failures++; $display("FAIL stop_ovr_clear got=%b required=0", ovr4);
    end
    tick();
    model_tick(0);
    wait_idle("stop_post");
    checks++;
    if (idx4 !== 2'd0) begin
      failures++; $display("FAIL stop_restart_idx got=%0d required=0", idx4);
    end
  endtask

  task automatic test_random_traffic();
    int md;
    rand_rdy = 1'b1;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 1) == 1)
        wr($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 127),
           ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 127));
      if ($urandom_range(0, 7) == 0) restart();
      md = $urandom_range(0, 3);
      mode = md[1:0];
      tick();
      model_tick(md);
      wait_idle("rnd");
      checks++;
      if (int'(idx4) != m_idx) begin
        failures++; $display("FAIL rnd_idx iter=%0d mode=%0d got=%0d required=%0d", k, md, idx4, m_idx);
      end
      while (rd < got_q.size()) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL rnd_msg got=%h required=none", got_q[rd]);
        end else begin
          if (got_q[rd] !== exp_q[0]) begin
            failures++; $display("FAIL rnd_msg got=%h required=%h", got_q[rd], exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        rd++;
      end
      checks++;
      if (exp_q.size() != 0) begin
        failures++; $display("FAIL rnd_missing left=%0d required=0", exp_q.size()); exp_q.delete();
      end
    end
    rand_rdy = 1'b0;
  endtask

  task automatic test_random_n5();
    logic [15:0] lf;
    int          exp_idx;
    bit          st;
    mode = 2'd3;
    run = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();
    rd = got_q.size();
    @(negedge clk);
    lf = 16'hACE1;
    st = 0;
    exp_idx = 0;
    for (int k = 0; k < 100; k++) begin
      if (!st) begin
        exp_idx = 0;
        st = 1;
      end else begin
        exp_idx = int'(lf) % 8;
        if (exp_idx >= 5) exp_idx -= 5;
      end
      lf = lfsr_adv(lf);
      tick();
      wait_idle("n5");
      checks++;
      if (int'(idx5) != exp_idx || idx5 >= 3'd5) begin
        failures++; $display("FAIL n5_idx tick=%0d got=%0d required=%0d", k, idx5, exp_idx);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_forward();
    test_two_track();
    test_pingpong();
    test_stall();
    test_stop();
    test_random_traffic();
    test_random_n5();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/poly_step_sequencer.md
Name: poly_step_sequencer

Overview:
Parametrised multi-track step sequencer core. It replaces the single-pattern player between the BPM clock (step pulse) and the MIDI note sender. It holds a writable note/velocity pattern per track and walks it in one of four play modes. Each step it emits correctly paired note-off/note-on MIDI messages over a valid/ready handshake, and it flushes hanging notes on stop.

Parameters:
NUM_STEPS, 8, steps per pattern (>=2); IDX_W = $clog2(NUM_STEPS)
NUM_TRACKS, 2, parallel tracks (1..16); TRK_W = max(1,$clog2(NUM_TRACKS))
CHANNEL_BASE, 4'd0, MIDI channel of track 0; track t uses CHANNEL_BASE+t mod 16
LFSR_SEED, 16'hACE1, reset value of random-mode LFSR (nonzero)

Ports:
clk  in  1  system clock (100 MHz)
rst_n  in  1  asynchronous active-low reset
step_tick  in  1  one-cycle step pulse from BPM clock
run  in  1  level; 1=play, 0=stop
mode  in  2  0 forward, 1 reverse, 2 ping-pong, 3 random
wr_en  in  1  pattern write strobe
wr_track  in  TRK_W  track to write
wr_step  in  IDX_W  step to write
wr_note  in  7  MIDI note
wr_vel  in  7  velocity; 0 = rest
msg_valid  out  1  MIDI message available
msg_ready  in  1  sender accepts (sender idle)
msg_status  out  8  0x9c note-on / 0x8c note-off
msg_data1  out  7  note
msg_data2  out  7  velocity (0 for note-off)
step_idx  out  IDX_W  step currently sounding
busy  out  1  FSM not IDLE
overrun  out  1  sticky: tick dropped while busy; cleared by reset or run 0->1

Behaviour:
- Reset: all outputs 0; pattern all rests (vel 0, note 0); active[] cleared; dir=up; LFSR=LFSR_SEED; started=0.
- Pattern: register array NUM_TRACKS x NUM_STEPS x 14 bits, written on wr_en any cycle. Out-of-range wr_track/wr_step are ignored. Note-on data is sampled at the send cycle. A write to the sounding step affects only later visits.
- Per-track active flag and active_note record exactly what was sent. Note-off always uses active_note, never the pattern.
- FSM states: IDLE, ADVANCE, SEND_OFF, SEND_ON, FLUSH.
- IDLE: step_tick & run -> ADVANCE. run falling with any active[] set -> FLUSH.
- ADVANCE (1 cycle): first tick after started=0 does not advance. It sets step_idx to 0 (NUM_STEPS-1 in reverse) and started=1. Otherwise step_idx advances per mode:
  - fwd: +1 with wrap N-1->0.
  - rev: -1 with wrap 0->N-1.
  - ping-pong: bounces, endpoints not repeated (0,1,..,N-1,N-2,..,1,0,1..).
  - random: r = lfsr[IDX_W-1:0]; if r>=NUM_STEPS then r-NUM_STEPS.
  - LFSR (x^16+x^14+x^13+x^11) steps once per ADVANCE in every mode.
  - trk=0 -> SEND_OFF.
- SEND_OFF: for trk ascending, if active[trk], present note-off. On msg_valid&msg_ready clear active[trk]. Inactive tracks are skipped in 1 cycle each. After last track, trk=0 -> SEND_ON.
- SEND_ON: for trk ascending, if pattern vel!=0, present note-on. On accept set active[trk], active_note. Rests are skipped. After last track -> IDLE.
- Handshake: msg_valid and all msg_* are registered and held stable until accepted; msg_valid drops the cycle after accept. There is no combinational ready->valid path. One message per accept; minimum 2 cycles per message.
- step_tick while FSM not IDLE: dropped, overrun<=1. Timing is not stretched.
- run=0 during ADVANCE/SEND_*: the current message finishes its handshake, then -> FLUSH.
- FLUSH: note-off for every active track ascending, then IDLE. started<=0, step_idx<=0, dir<=up.
- mode change: sampled in ADVANCE only. Entering ping-pong sets dir=up. A step_idx out of range for the new mode cannot occur.
- Reset mid-message: msg_valid drops immediately. Hanging notes are the system's responsibility (sender is reset too).
- busy = (state != IDLE).

Test Plan:
1. Reset, write t0 steps 0..3 notes 60..63 vel 100, NUM_STEPS=4, mode 0, msg_ready=1, 6 ticks -> messages 90 3C 64; 80 3C 00,90 3D 64; ...; after step3 wraps to 90 3C 64; step_idx 0,1,2,3,0,1.
2. Ping-pong, N=4, 8 ticks -> step_idx 0,1,2,3,2,1,0,1.
3. Two tracks, t1 step0 note 48 vel 80, t1 step1 rest -> step1 issues 80 3C, 81 30, 90 3D in that order; no note-on for t1.
4. msg_ready held 0 for 20 cycles -> msg_valid/status/data stable; tick during stall -> overrun=1, step_idx unchanged.
5. Random mode, N=5, 100 ticks -> step_idx always <5, sequence matches LFSR model seeded 16'hACE1.
6. run->0 while t0,t1 active -> 80 xx, 81 xx then busy=0; run->1 then tick -> step_idx=0, overrun=0.
